// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the BPI flash bus sequencer.
// Holds the state encoding, counter width and default pin timing in cycles.
package flash_seq_pkg;

  localparam int CNT_W = 8;

  localparam int DEF_T_SETUP      = 2;
  localparam int DEF_T_RD         = 8;
  localparam int DEF_T_WE         = 6;
  localparam int DEF_T_HOLD       = 2;
  localparam int DEF_T_TURN       = 2;
  localparam int DEF_WAIT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_ACC,
    WR_PULSE,
    HOLD,
    RESP,
    TURN
  } seq_state_t;

  // A timed state lasting N cycles starts its counter at N-1 and leaves at 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// Loadable down-counter shared by every timed state of the flash sequencer.
// It counts down to zero and then holds there until the next load.
module flash_seq_timer
  import flash_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/flash_bus_sequencer.sv
// Asynchronous read/write cycle sequencer for the ML605 BPI parallel NOR flash.
// Takes one word request at a time and returns read data or write completion.
module flash_bus_sequencer
  import flash_seq_pkg::*;
#(
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_RD         = DEF_T_RD,
  parameter int T_WE         = DEF_T_WE,
  parameter int T_HOLD       = DEF_T_HOLD,
  parameter int T_TURN       = DEF_T_TURN,
  parameter bit WAIT_EN      = 1'b0,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [23:0] flash_addr,
  output logic [15:0] flash_dq_o,
  output logic        flash_dq_oe,
  input  logic [15:0] flash_dq_i,
  input  logic        flash_fwait_i,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n
);

  seq_state_t state, state_next;

  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic        stretch_q, stretch_d;
  logic [15:0] rdata_q, rdata_d;

  logic [23:0] addr_d;
  logic [15:0] dq_o_d;
  logic        dq_oe_d;
  logic        ce_n_d;
  logic        oe_n_d;
  logic        we_n_d;
  logic        rsp_valid_d;
  logic        rsp_err_d;
  logic [15:0] rsp_rdata_d;
  logic        busy_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_value;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;

  logic wait_active;
  logic rd_capture;

  assign req_ready   = (state == IDLE) & rst_n;
  assign wait_active = WAIT_EN & flash_fwait_i;

  flash_seq_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .done       (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    tmr_load       = 1'b0;
    tmr_load_value = tmr_value;
    rd_capture     = 1'b0;
    wr_d           = wr_q;
    err_d          = err_q;
    stretch_d      = stretch_q;
    rdata_d        = rdata_q;
    addr_d         = flash_addr;
    dq_o_d         = flash_dq_o;
    dq_oe_d        = flash_dq_oe;
    ce_n_d         = flash_ce_n;
    oe_n_d         = flash_oe_n;
    we_n_d         = flash_we_n;
    rsp_valid_d    = rsp_valid;
    rsp_err_d      = rsp_err;
    rsp_rdata_d    = rsp_rdata;

    case (state)
      IDLE: begin
        if (req_valid) begin
          wr_d           = req_write;
          err_d          = 1'b0;
          stretch_d      = 1'b0;
          addr_d         = req_addr;
          ce_n_d         = 1'b0;
          if (req_write) begin
            dq_o_d  = req_wdata;
            dq_oe_d = 1'b1;
          end
          tmr_load       = 1'b1;
          tmr_load_value = cnt_load(T_SETUP);
          state_next     = SETUP;
        end
      end

      SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (wr_q) begin
            we_n_d         = 1'b0;
            tmr_load_value = cnt_load(T_WE);
            state_next     = WR_PULSE;
          end else begin
            oe_n_d         = 1'b0;
            tmr_load_value = cnt_load(T_RD);
            state_next     = RD_ACC;
          end
        end
      end

      RD_ACC: begin
        // Once the base access time is up, WAIT stretches one cycle at a time,
        // reusing the timer as the timeout budget.
        if (!stretch_q) begin
          if (tmr_done) begin
            if (wait_active) begin
              stretch_d      = 1'b1;
              tmr_load       = 1'b1;
              tmr_load_value = cnt_load(WAIT_TIMEOUT);
            end else begin
              rd_capture = 1'b1;
            end
          end
        end else if (!wait_active) begin
          rd_capture = 1'b1;
        end else if (tmr_done) begin
          rd_capture = 1'b1;
          err_d      = 1'b1;
        end
        if (rd_capture) begin
          rdata_d        = flash_dq_i;
          oe_n_d         = 1'b1;
          stretch_d      = 1'b0;
          tmr_load       = 1'b1;
          tmr_load_value = cnt_load(T_HOLD);
          state_next     = HOLD;
        end
      end

      WR_PULSE: begin
        if (tmr_done) begin
          we_n_d         = 1'b1;
          tmr_load       = 1'b1;
          tmr_load_value = cnt_load(T_HOLD);
          state_next     = HOLD;
        end
      end

      HOLD: begin
        if (tmr_done) begin
          ce_n_d      = 1'b1;
          dq_oe_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = wr_q ? 16'h0000 : rdata_q;
          state_next  = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (T_TURN > 0) begin
            tmr_load       = 1'b1;
            tmr_load_value = cnt_load(T_TURN);
            state_next     = TURN;
          end else begin
            state_next = IDLE;
          end
        end
      end

      TURN: begin
        if (tmr_done) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_d = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      stretch_q   <= 1'b0;
      rdata_q     <= '0;
      flash_addr  <= '0;
      flash_dq_o  <= '0;
      flash_dq_oe <= 1'b0;
      flash_ce_n  <= 1'b1;
      flash_oe_n  <= 1'b1;
      flash_we_n  <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      err_q       <= err_d;
      stretch_q   <= stretch_d;
      rdata_q     <= rdata_d;
      flash_addr  <= addr_d;
      flash_dq_o  <= dq_o_d;
      flash_dq_oe <= dq_oe_d;
      flash_ce_n  <= ce_n_d;
      flash_oe_n  <= oe_n_d;
      flash_we_n  <= we_n_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_rdata   <= rsp_rdata_d;
      busy        <= busy_d;
    end
  end

endmodule
